// File: rtl/fifo_rd_pkt_pkg.sv
// rtl/fifo_rd_pkt_pkg.sv - shared defaults, FSM encoding and helpers for the FIFO read-side packetiser
package fifo_rd_pkt_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_PKT_LEN    = 4;
    localparam int DEF_PKT_CNT_W  = 16;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } pkt_state_t;

    function automatic int beat_width(input int len);
        return (len > 1) ? $clog2(len) : 1;
    endfunction

endpackage

// File: rtl/fifo_out_skid.sv
// rtl/fifo_out_skid.sv - 2-entry circular output buffer with push/pop and occupancy
module fifo_out_skid #(
    parameter int W = 9
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [1:0]   occ,
    output logic [W-1:0] head
);

    logic [W-1:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            occ    <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: occ <= occ;
            endcase
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/fifo_rd_pkt.sv
// rtl/fifo_rd_pkt.sv - pops a show-ahead FIFO into a packetised valid/ready stream
module fifo_rd_pkt
    import fifo_rd_pkt_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int PKT_LEN    = DEF_PKT_LEN,
    parameter int PKT_CNT_W  = DEF_PKT_CNT_W
) (
    input  logic                  rd_clk,
    input  logic                  rd_rst,
    input  logic                  en,
    input  logic                  rd_empty,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_en,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic [PKT_CNT_W-1:0]  pkt_cnt,
    output logic                  busy
);

    localparam int              BEAT_W   = beat_width(PKT_LEN);
    localparam logic [BEAT_W-1:0] BEAT_MAX = BEAT_W'(PKT_LEN - 1);

    logic [BEAT_W-1:0]    beat;
    logic [1:0]           occ;
    logic [DATA_WIDTH:0]  head;
    logic                 push;
    logic                 push_last;
    logic                 pop;
    pkt_state_t           state;
    pkt_state_t           state_d;
    logic [PKT_CNT_W-1:0] pkt_cnt_d;

    // Never pop while the buffer is full, so downstream stalls cannot drop words.
    assign rd_en     = en & ~rd_empty & (occ < 2'd2) & ~rd_rst;
    assign push      = rd_en;
    assign push_last = (beat == BEAT_MAX);
    assign out_valid = (occ != 2'd0);
    assign pop       = out_valid & out_ready;
    assign out_last  = head[DATA_WIDTH];
    assign out_data  = head[DATA_WIDTH-1:0];
    assign busy      = (state == BURST) | (occ != 2'd0) | (beat != '0);

    fifo_out_skid #(
        .W (DATA_WIDTH + 1)
    ) u_skid (
        .clk       (rd_clk),
        .rst       (rd_rst),
        .push      (push),
        .push_data ({push_last, rd_data}),
        .pop       (pop),
        .occ       (occ),
        .head      (head)
    );

    always_ff @(posedge rd_clk) begin
        if (rd_rst) begin
            beat <= '0;
        end else if (push) begin
            beat <= push_last ? '0 : beat + 1'b1;
        end
    end

    always_ff @(posedge rd_clk) begin
        if (rd_rst) begin
            state   <= IDLE;
            pkt_cnt <= '0;
        end else begin
            state   <= state_d;
            pkt_cnt <= pkt_cnt_d;
        end
    end

    always_comb begin
        state_d   = state;
        pkt_cnt_d = pkt_cnt;
        case (state)
            IDLE: begin
                if (pop) begin
                    if (out_last) begin
                        pkt_cnt_d = pkt_cnt + 1'b1;
                    end else begin
                        state_d = BURST;
                    end
                end
            end
            BURST: begin
                if (pop && out_last) begin
                    state_d   = IDLE;
                    pkt_cnt_d = pkt_cnt + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule
